// File: rtl/hdmi_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_pkg
// Shared definitions for the HDMI pixel-source scheduler:
//   - sched_state_e    : scheduler FSM state encoding
//   - RGB_W            : width of one {R,G,B} pixel (24)
//   - IDLE_RGB_DEFAULT : colour shown in the active area when nobody owns the output
//   - rgb_select()     : active-area colour selection helper
// -----------------------------------------------------------------------------
package hdmi_pkg;

  localparam int RGB_W = 24;

  localparam logic [RGB_W-1:0] IDLE_RGB_DEFAULT = 24'h000080;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,  // no owner
    ST_GRANTED  = 2'd1,  // one owner streaming
    ST_HANDOVER = 2'd2   // new owner applied this cycle, settles into GRANTED
  } sched_state_e;

  // Blanking forces black; active area shows the owner or the idle colour.
  function automatic logic [RGB_W-1:0] rgb_select(
    input logic             de,
    input logic             owned,
    input logic [RGB_W-1:0] owner_pix,
    input logic [RGB_W-1:0] idle_pix
  );
    logic [RGB_W-1:0] res;
    if (!de) begin
      res = {RGB_W{1'b0}};
    end else if (owned) begin
      res = owner_pix;
    end else begin
      res = idle_pix;
    end
    return res;
  endfunction

endpackage

// File: rtl/hdmi_source_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts at the index just
// above last_i and wraps from NREQ-1 back to 0, so last_i itself has the lowest
// priority.
// Ports:
//   req_i   [NREQ-1:0] candidate requests
//   last_i  [PW-1:0]   index of the previous owner
//   gnt_o   [NREQ-1:0] one-hot winner (zero when nobody requests)
//   idx_o   [PW-1:0]   binary index of the winner
//   valid_o            a winner exists
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            valid_o
);

  // Two passes: first the indices above last_i, then the wrapped-around ones.
  always_comb begin
    gnt_o   = {NREQ{1'b0}};
    idx_o   = {PW{1'b0}};
    valid_o = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid_o && req_i[i] && (i > int'(last_i))) begin
        gnt_o[i] = 1'b1;
        idx_o    = PW'(i);
        valid_o  = 1'b1;
      end else begin
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!valid_o && req_i[i] && (i <= int'(last_i))) begin
        gnt_o[i] = 1'b1;
        idx_o    = PW'(i);
        valid_o  = 1'b1;
      end else begin
      end
    end
  end

endmodule

// File: rtl/hdmi_source_scheduler.sv
// -----------------------------------------------------------------------------
// hdmi_source_scheduler
// Frame-granular owner scheduler for several pixel sources that share one
// HDMI output. Ownership may change only on the FRAME_END cycle. The timing
// signals and the selected pixel are re-registered with one cycle of latency.
//
// Optional feature: define HDMI_SCHED_FAIR_EN to make the owner give up the
// output after MAX_FRAMES frames when another source is waiting. Without the
// macro the owner keeps the output until it drops its request, and there is
// no frame counter.
//
// Ports:
//   CLK_PX                       pixel clock
//   RST_n                        asynchronous active-low reset
//   FRAME_END                    pulse on the last pixel clock of a frame
//   DE_IN, HSYNC_IN, VSYNC_IN    timing from the generator (syncs active-low)
//   REQ      [NREQ-1:0]          per-source request level
//   PIX_IN   [24*NREQ-1:0]       source pixels, source i at [24*i +: 24], {R,G,B}
//   GNT      [NREQ-1:0]          current owner, one-hot or zero
//   DE, HSYNC, VSYNC             timing delayed by one register
//   RED, GREEN, BLUE [7:0]       registered pixel
// -----------------------------------------------------------------------------
module hdmi_source_scheduler
  import hdmi_pkg::*;
#(
  parameter int               NREQ       = 2,
  parameter int               MAX_FRAMES = 4,
  parameter logic [RGB_W-1:0] IDLE_RGB   = IDLE_RGB_DEFAULT
) (
  input  logic                  CLK_PX,
  input  logic                  RST_n,
  input  logic                  FRAME_END,
  input  logic                  DE_IN,
  input  logic                  HSYNC_IN,
  input  logic                  VSYNC_IN,
  input  logic [NREQ-1:0]       REQ,
  input  logic [RGB_W*NREQ-1:0] PIX_IN,
  output logic [NREQ-1:0]       GNT,
  output logic                  DE,
  output logic                  HSYNC,
  output logic                  VSYNC,
  output logic [7:0]            RED,
  output logic [7:0]            GREEN,
  output logic [7:0]            BLUE
);

  localparam int            PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Pointer starts at the top index so that source 0 wins the first search.
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  sched_state_e     state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;     // last owner; equals current owner while granted

  logic             owner_req_s;
  logic             other_req_s;
  logic [NREQ-1:0]  arb_req_s;
  logic [NREQ-1:0]  arb_gnt_s;
  logic [PW-1:0]    arb_idx_s;
  logic             arb_valid_s;
  logic             preempt_s;

  logic             de_q, de_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [RGB_W-1:0] owner_pix_s;

  // The owner is masked so a handover can only move to a different source.
  assign owner_req_s = |(REQ & gnt_q);
  assign other_req_s = |(REQ & ~gnt_q);
  assign arb_req_s   = REQ & ~gnt_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .req_i   (arb_req_s),
    .last_i  (ptr_q),
    .gnt_o   (arb_gnt_s),
    .idx_o   (arb_idx_s),
    .valid_o (arb_valid_s)
  );

`ifdef HDMI_SCHED_FAIR_EN
  localparam int            CW_RAW  = $clog2(MAX_FRAMES + 1);
  localparam int            CW      = (CW_RAW > 3) ? CW_RAW : 3;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_FRAMES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc_s;

  // cnt_inc_s counts the frame that is ending now, so the limit is hit on the
  // MAX_FRAMES-th FRAME_END after the grant.
  assign cnt_inc_s = (cnt_q >= MAX_CNT) ? MAX_CNT : (cnt_q + CNT_ONE);
  assign preempt_s = other_req_s && (cnt_inc_s >= MAX_CNT);

  // Frame counter: cleared on any grant change, advanced on FRAME_END while owned.
  always_comb begin
    cnt_d = cnt_q;
    if (gnt_d != gnt_q) begin
      cnt_d = {CW{1'b0}};
    end else if (FRAME_END && (state_q != ST_IDLE)) begin
      cnt_d = cnt_inc_s;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign preempt_s = 1'b0;
`endif

  // Scheduler next-state: decisions are taken only on the FRAME_END cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    if (FRAME_END) begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid_s) begin
            state_d = ST_HANDOVER;
            gnt_d   = arb_gnt_s;
            ptr_d   = arb_idx_s;
          end else begin
            state_d = ST_IDLE;
          end
        end
        // A one-cycle frame could end while in HANDOVER; treat it as owned.
        ST_GRANTED, ST_HANDOVER: begin
          if (!owner_req_s || preempt_s) begin
            if (arb_valid_s) begin
              state_d = ST_HANDOVER;
              gnt_d   = arb_gnt_s;
              ptr_d   = arb_idx_s;
            end else begin
              state_d = ST_IDLE;
              gnt_d   = {NREQ{1'b0}};
            end
          end else begin
            state_d = ST_GRANTED;
          end
        end
        default: begin
          state_d = ST_IDLE;
          gnt_d   = {NREQ{1'b0}};
        end
      endcase
    end else begin
      case (state_q)
        ST_HANDOVER: state_d = ST_GRANTED;
        ST_IDLE:     state_d = ST_IDLE;
        ST_GRANTED:  state_d = ST_GRANTED;
        default: begin
          state_d = ST_IDLE;
          gnt_d   = {NREQ{1'b0}};
        end
      endcase
    end
  end

  // Scheduler state, grant and round-robin pointer registers.
  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= {NREQ{1'b0}};
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Owner pixel slice; the grant is one-hot, so an OR of masked slices is a mux.
  always_comb begin
    owner_pix_s = {RGB_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      owner_pix_s = owner_pix_s |
                    (gnt_q[i] ? PIX_IN[RGB_W*i +: RGB_W] : {RGB_W{1'b0}});
    end
  end

  // Output stage inputs: the current grant (not the next) selects the pixel.
  always_comb begin
    de_d    = DE_IN;
    hsync_d = HSYNC_IN;
    vsync_d = VSYNC_IN;
    rgb_d   = rgb_select(DE_IN, |gnt_q, owner_pix_s, IDLE_RGB);
  end

  // Output registers; syncs idle high because they are active-low.
  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      de_q    <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= {RGB_W{1'b0}};
    end else begin
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign GNT   = gnt_q;
  assign DE    = de_q;
  assign HSYNC = hsync_q;
  assign VSYNC = vsync_q;
  assign RED   = rgb_q[23:16];
  assign GREEN = rgb_q[15:8];
  assign BLUE  = rgb_q[7:0];

endmodule

// File: doc/hdmi_source_scheduler.md
HDMI_SOURCE_SCHEDULER -- requirements
Module: hdmi_source_scheduler

Interface
REQ-001 Parameter NREQ, default 2: number of pixel-source requesters, range 2..4.
REQ-002 Parameter MAX_FRAMES, default 4: consecutive frames an owner may hold the output while another source is waiting.
REQ-003 Parameter IDLE_RGB, default 24'h000080: colour driven in active area when no source owns the output.
REQ-004 CLK_PX  input  1  pixel clock; all state on rising edge.
REQ-005 RST_n  input  1  reset; asynchronous, active-low.
REQ-006 FRAME_END  input  1  one-cycle pulse on the last pixel clock of a frame, from the timing generator.
REQ-007 DE_IN, HSYNC_IN, VSYNC_IN  input  1 each  timing from the generator; syncs are active-low.
REQ-008 REQ  input  NREQ  per-source request level.
REQ-009 PIX_IN  input  24*NREQ  source pixels; source i occupies bits [24*i+23:24*i], ordered {R,G,B}.
REQ-010 GNT  output  NREQ  one-hot or zero; the current owner.
REQ-011 DE, HSYNC, VSYNC  output  1 each  registered timing.
REQ-012 RED, GREEN, BLUE  output  8 each  registered pixel.

Function
REQ-013 FSM states: IDLE (no owner), GRANTED (one owner), HANDOVER (new owner chosen, applied next cycle).
REQ-014 Arbitration SHALL be evaluated only in the cycle FRAME_END=1, using REQ sampled in that same cycle; GNT SHALL never change at any other time.
REQ-015 Owner selection: round-robin, searching upward from the index after the last owner, with wrap at NREQ-1 -> 0.
REQ-016 IDLE + FRAME_END + any REQ: go to HANDOVER; GNT becomes one-hot on the next cycle, and the first pixel of the following frame comes from the new owner.
REQ-017 GRANTED + FRAME_END + owner REQ=0: release; go to HANDOVER if another source requests, else go to IDLE with GNT=0.
REQ-018 GRANTED + FRAME_END + owner REQ=1 + no other REQ: keep the owner; frame counter saturates at MAX_FRAMES.
REQ-019 Owner REQ dropped mid-frame: the grant is held until FRAME_END, and the owner pixels continue to be output.
REQ-020 Output latency: exactly 1 cycle. DE, HSYNC and VSYNC equal the inputs delayed by one register stage.
REQ-021 RGB source selection, evaluated on the input-side cycle:
  - DE_IN=0: RGB=0.
  - DE_IN=1 and owner present: RGB = owner slice of PIX_IN.
  - DE_IN=1 and no owner: RGB = IDLE_RGB.
REQ-022 Frame counter: 3-bit minimum, sized to hold MAX_FRAMES; cleared on every grant change and incremented at each FRAME_END while GRANTED.

Reset
REQ-023 On RST_n=0, immediately:
  - state=IDLE, GNT=0, round-robin pointer=NREQ-1, frame counter=0;
  - DE=0, HSYNC=1, VSYNC=1, RGB=0.
REQ-024 Reset asserted mid-frame SHALL discard the grant; after release, no grant is issued before the next FRAME_END.

Configuration
REQ-025 Macro HDMI_SCHED_FAIR_EN defined: in GRANTED, at FRAME_END, if the frame counter has reached MAX_FRAMES and another REQ is high, the scheduler SHALL preempt the owner and hand over round-robin.
REQ-026 Macro HDMI_SCHED_FAIR_EN undefined: the owner keeps the grant until it drops REQ; the frame counter and MAX_FRAMES logic are absent.

Structure
REQ-027 Shared package hdmi_pkg SHALL hold the FSM state encodings, RGB width constant 24, and the IDLE_RGB default.
REQ-028 One sub-module, rr_arbiter: combinational round-robin pick of (REQ, last pointer) -> one-hot, plus a valid flag. The FSM and registers stay in hdmi_source_scheduler.

Verification
REQ-029 Reset, then REQ=2'b01, FRAME_END pulse -> GNT=2'b01 one cycle later; next active pixel RGB equals PIX_IN[23:0].
REQ-030 REQ=2'b11 from IDLE, last owner reset pointer 1 -> source 0 granted first. After it drops REQ, source 1 is granted at the next FRAME_END.
REQ-031 Owner drops REQ mid-frame -> GNT unchanged and RGB still from the owner until FRAME_END; then GNT=0 and active pixels equal 24'h000080.
REQ-032 With HDMI_SCHED_FAIR_EN, MAX_FRAMES=4, both sources requesting continuously -> GNT alternates every 4 FRAME_END pulses. Without the macro -> GNT stays 2'b01 indefinitely.
REQ-033 Apply HSYNC_IN, VSYNC_IN, DE_IN patterns -> outputs match the inputs delayed exactly 1 cycle, and RGB=0 whenever DE=0.
REQ-034 RST_n pulsed low mid-frame while granted -> GNT=0 and HSYNC=VSYNC=1 immediately; no grant before the next FRAME_END.
